// File: rtl/rv32i_pkg.sv
// Shared encodings for the single-cycle RV32I core: opcodes, funct3 codes,
// ALU operation set and the default memory-map base addresses.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  localparam logic [31:0] DMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] IO_BASE   = 32'hF000_0000;

endpackage

// File: rtl/rv32i_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, synchronous clear on reset.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_we,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) registers[i] <= '0;
    end else if (rd_we && rd_addr != '0) begin
      registers[rd_addr] <= rd_data;
    end
  end

  // Reads see the pre-edge contents, so same-cycle writes are not forwarded.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : registers[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : registers[rs2_addr];
  end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with internal instruction ROM, byte-addressable
// data RAM and memory-mapped switch/LED registers.
module rv32i_core #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [31:0] DMEM_BASE  = rv32i_pkg::DMEM_BASE,
  parameter logic [31:0] IO_BASE    = rv32i_pkg::IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  import rv32i_pkg::*;

  localparam int unsigned IW = $clog2(IMEM_WORDS);
  localparam int unsigned DW = $clog2(DMEM_WORDS);
  localparam logic [31:0] IO_LED = IO_BASE + 32'd4;

  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [15:0] led_q, led_d;

  if (1) begin : im
    logic [31:0] instr_rom [0:IMEM_WORDS-1];
    always_comb instr = instr_rom[pc_q[IW+1:2]];
  end

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    opcode = instr[6:0];
    rd     = instr[11:7];
    funct3 = instr[14:12];
    rs1    = instr[19:15];
    rs2    = instr[24:20];
    funct7 = instr[31:25];
    imm_i  = {{20{instr[31]}}, instr[31:20]};
    imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u  = {instr[31:12], 12'b0};
    imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  logic [31:0] rs1_val, rs2_val, rd_val;
  logic        rd_we;

  rv32i_regfile register_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .rd_we    (rd_we && !rst),
    .rd_data  (rd_val),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val)
  );

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic [4:0]  shamt;

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (opcode == OP_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_b = (opcode == OP_OP) ? rs2_val : imm_i;
    shamt = alu_b[4:0];
    case (alu_op)
      ALU_ADD:  alu_y = rs1_val + alu_b;
      ALU_SUB:  alu_y = rs1_val - alu_b;
      ALU_SLL:  alu_y = rs1_val << shamt;
      ALU_SLT:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, rs1_val < alu_b};
      ALU_XOR:  alu_y = rs1_val ^ alu_b;
      ALU_SRL:  alu_y = rs1_val >> shamt;
      ALU_SRA:  alu_y = 32'($signed(rs1_val) >>> shamt);
      ALU_OR:   alu_y = rs1_val | alu_b;
      ALU_AND:  alu_y = rs1_val & alu_b;
      default:  alu_y = '0;
    endcase
  end

  logic br_taken;

  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] dmem_q [0:DMEM_WORDS-1];
  logic [31:0] mem_addr, dm_off, ld_word, ld_val, st_data;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [3:0]  st_be;
  logic [DW-1:0] dm_idx;
  logic        is_store, dmem_we;

  // Low address bits select lanes only; the word index ignores them,
  // so misaligned accesses fall back to the containing aligned word.
  always_comb begin
    is_store = (opcode == OP_STORE);
    mem_addr = rs1_val + (is_store ? imm_s : imm_i);
    dm_off   = mem_addr - DMEM_BASE;
    dm_idx   = dm_off[DW+1:2];
    ld_word  = '0;
    case (mem_addr[31:28])
      4'h8: ld_word = dmem_q[dm_idx];
      4'hF: begin
        if (mem_addr[31:2] == IO_BASE[31:2])     ld_word = {16'b0, sw};
        else if (mem_addr[31:2] == IO_LED[31:2]) ld_word = {16'b0, led_q};
      end
      default: ld_word = '0;
    endcase
    ld_byte = ld_word[{mem_addr[1:0], 3'b000} +: 8];
    ld_half = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
    case (funct3)
      F3_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_val = ld_word;
      F3_LBU:  ld_val = {24'b0, ld_byte};
      F3_LHU:  ld_val = {16'b0, ld_half};
      default: ld_val = '0;
    endcase
  end

  always_comb begin
    st_be   = '0;
    st_data = rs2_val;
    case (funct3)
      F3_SB: begin
        st_be   = 4'b0001 << mem_addr[1:0];
        st_data = {4{rs2_val[7:0]}};
      end
      F3_SH: begin
        st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      F3_SW:   st_be = 4'b1111;
      default: st_be = '0;
    endcase
    dmem_we = is_store && (mem_addr[31:28] == 4'h8) && !rst;
  end

  always_ff @(posedge clk) begin
    if (dmem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) dmem_q[dm_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    rd_we    = 1'b0;
    rd_val   = alu_y;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      OP_JAL: begin
        rd_we  = 1'b1;
        rd_val = pc_plus4;
        pc_d   = pc_q + imm_j;
      end
      OP_JALR: begin
        rd_we  = 1'b1;
        rd_val = pc_plus4;
        pc_d   = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; rd_val = ld_val; end
      OP_IMM, OP_OP: rd_we = 1'b1;
      default: ;
    endcase
    if (rst) pc_d = '0;
  end

  always_comb begin
    led_d = led_q;
    if (is_store && mem_addr[31:2] == IO_LED[31:2]) led_d = rs2_val[15:0];
    if (rst) led_d = '0;
  end

  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    led_q <= led_d;
  end

  always_comb led = led_q;

  logic unused_bits;
  always_comb unused_bits = ^{dm_off[31:DW+2], dm_off[1:0]};

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: loads hand-assembled programs into the ROM
// and checks architectural state against hand-computed values.
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw  = 16'h0000;
  logic [15:0] led;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] prog [$];

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] PARK = 32'h0000_006F;

  rv32i_core dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .led (led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] itype(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                                        logic [4:0] rs1, int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                                        logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] stype(logic [2:0] f3, logic [4:0] rs2, logic [4:0] rs1, int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] btype(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
  endfunction

  function automatic logic [31:0] utype(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] jtype(logic [4:0] rd, int off);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, int imm);
    return itype(7'h13, 3'b000, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] xreg(int i);
    return dut.register_file.registers[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) dut.im.instr_rom[i] = (i < prog.size()) ? prog[i] : NOP;
    prog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic check_all_clear(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 1; i < 32; i++) acc = acc | xreg(i);
    check(tag, acc, 32'h0);
  endtask

  initial begin
    // Program 1: word / halfword / byte stores and loads, lane boundaries.
    prog.push_back(addi(8, 0, 123));
    prog.push_back(utype(7'h37, 9, 20'h80000));
    prog.push_back(stype(3'b010, 8, 9, 0));
    prog.push_back(itype(7'h03, 3'b010, 1, 9, 0));
    prog.push_back(addi(7, 0, 532));
    prog.push_back(stype(3'b001, 7, 9, 0));
    prog.push_back(itype(7'h03, 3'b001, 3, 9, 0));
    prog.push_back(addi(11, 0, -1));
    prog.push_back(stype(3'b000, 11, 9, 0));
    prog.push_back(itype(7'h03, 3'b000, 4, 9, 0));
    prog.push_back(itype(7'h03, 3'b001, 28, 9, 0));
    prog.push_back(itype(7'h03, 3'b100, 29, 9, 0));
    prog.push_back(stype(3'b010, 11, 9, 0));
    prog.push_back(itype(7'h03, 3'b101, 30, 9, 0));
    prog.push_back(stype(3'b000, 8, 9, 3));
    prog.push_back(itype(7'h03, 3'b100, 31, 9, 3));
    prog.push_back(itype(7'h03, 3'b001, 27, 9, 2));
    prog.push_back(itype(7'h03, 3'b010, 26, 9, 1));
    prog.push_back(PARK);
    load_rom();
    do_reset();

    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check_all_clear("reset_regs");

    step(24);
    check("lw_x1", xreg(1), 32'd123);
    check("lh_x3", xreg(3), 32'd532);
    check("lb_x4", xreg(4), 32'hFFFF_FFFF);
    check("lh_x28", xreg(28), 32'h0000_02FF);
    check("lbu_x29", xreg(29), 32'h0000_00FF);
    check("lhu_x30", xreg(30), 32'h0000_FFFF);
    check("lbu_b3_x31", xreg(31), 32'h0000_007B);
    check("lh_hi_x27", xreg(27), 32'h0000_7BFF);
    check("lw_misal_x26", xreg(26), 32'h7BFF_FFFF);
    check("dmem_word0", dut.dmem_q[0], 32'h7BFF_FFFF);

    // Program 2: ALU, branches, jumps, x0, unmapped memory, NOP-class opcodes.
    prog.push_back(addi(1, 0, -5));
    prog.push_back(itype(7'h13, 3'b010, 2, 1, 0));
    prog.push_back(itype(7'h13, 3'b011, 3, 1, 0));
    prog.push_back(itype(7'h13, 3'b101, 4, 1, 32'h401));
    prog.push_back(btype(3'b001, 2, 0, 8));
    prog.push_back(addi(6, 0, 99));
    prog.push_back(jtype(5, 8));
    prog.push_back(addi(6, 0, 77));
    prog.push_back(addi(0, 0, 7));
    prog.push_back(rtype(7'h20, 3'b000, 7, 0, 1));
    prog.push_back(addi(10, 0, 33));
    prog.push_back(rtype(7'h00, 3'b001, 8, 7, 10));
    prog.push_back(rtype(7'h00, 3'b101, 12, 1, 10));
    prog.push_back(rtype(7'h00, 3'b011, 13, 2, 1));
    prog.push_back(btype(3'b100, 1, 0, 8));
    prog.push_back(addi(6, 0, 55));
    prog.push_back(btype(3'b110, 1, 0, 8));
    prog.push_back(addi(14, 0, 1));
    prog.push_back(utype(7'h17, 15, 20'h00001));
    prog.push_back(itype(7'h67, 3'b000, 16, 0, 85));
    prog.push_back(addi(6, 0, 44));
    prog.push_back(utype(7'h37, 17, 20'h10000));
    prog.push_back(addi(18, 0, 9));
    prog.push_back(stype(3'b010, 7, 17, 0));
    prog.push_back(itype(7'h03, 3'b010, 18, 17, 0));
    prog.push_back(32'h0000_0073);
    prog.push_back(32'hFFFF_FFFF);
    prog.push_back(PARK);
    load_rom();
    do_reset();
    step(32);

    check("slti_x2", xreg(2), 32'd1);
    check("sltiu_x3", xreg(3), 32'd0);
    check("srai_x4", xreg(4), 32'hFFFF_FFFD);
    check("jal_link_x5", xreg(5), 32'd28);
    check("skipped_x6", xreg(6), 32'd0);
    check("sub_x7", xreg(7), 32'd5);
    check("sll_shamt5_x8", xreg(8), 32'd10);
    check("srl_x12", xreg(12), 32'h7FFF_FFFD);
    check("sltu_x13", xreg(13), 32'd1);
    check("bltu_fall_x14", xreg(14), 32'd1);
    check("auipc_x15", xreg(15), 32'h0000_1048);
    check("jalr_link_x16", xreg(16), 32'd80);
    check("unmapped_ld_x18", xreg(18), 32'd0);
    check("x0_zero", xreg(0), 32'd0);
    check("unknown_op_x31", xreg(31), 32'd0);
    check("park_pc", dut.pc_q, 32'd108);

    // Program 3: switch/LED I/O, RAM retention across reset, mid-program reset.
    sw = 16'hA5A5;
    prog.push_back(utype(7'h37, 9, 20'hF0000));
    prog.push_back(itype(7'h03, 3'b010, 1, 9, 0));
    prog.push_back(addi(2, 0, 32'h3C));
    prog.push_back(stype(3'b010, 2, 9, 4));
    prog.push_back(itype(7'h03, 3'b010, 3, 9, 4));
    prog.push_back(stype(3'b000, 1, 9, 4));
    prog.push_back(utype(7'h37, 5, 20'h80000));
    prog.push_back(itype(7'h03, 3'b010, 6, 5, 0));
    prog.push_back(stype(3'b010, 0, 5, 0));
    prog.push_back(PARK);
    load_rom();
    do_reset();

    step(3);
    check("led_before_sw", {16'h0, led}, 32'h0);
    step(1);
    check("led_after_sw", {16'h0, led}, 32'h0000_003C);
    step(4);
    check("io_sw_x1", xreg(1), 32'h0000_A5A5);
    check("io_led_rd_x3", xreg(3), 32'h0000_003C);
    check("led_sb", {16'h0, led}, 32'h0000_A5A5);
    check("ram_kept_x6", xreg(6), 32'h7BFF_FFFF);
    check("pc_before_rst", dut.pc_q, 32'd32);

    rst = 1'b1;
    step(1);
    check("midrst_pc", dut.pc_q, 32'h0);
    check_all_clear("midrst_regs");
    check("midrst_led", {16'h0, led}, 32'h0);
    check("midrst_no_store", dut.dmem_q[0], 32'h7BFF_FFFF);

    rst = 1'b0;
    sw  = 16'h1234;
    step(2);
    check("restart_x1", xreg(1), 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I processor; the top-level compute block of the FPGA design.
- Fetches from an internal instruction ROM, executes one instruction per clock and accesses an internal byte-addressable data RAM.
- Exposes 16 switches (input) and 16 LEDs (output) as memory-mapped I/O.

Parameters:
- IMEM_WORDS, 256, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 1024, data RAM depth in 32-bit words.
- DMEM_BASE, 32'h8000_0000, base byte address of data RAM.
- IO_BASE, 32'hF000_0000, base byte address of the I/O registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw   input  16  switch inputs.
- led  output  16  LED register outputs.

Behaviour:
- Reset (rst=1 at a clock edge):
  - PC=0.
  - All 32 registers cleared.
  - led=0.
  - Data RAM contents preserved.
  - Reset mid-program aborts the current instruction with no writeback and no store.
- Execution model:
  - One instruction completes per cycle; no pipeline and no stalls.
  - PC, register writeback and memory store all commit on the same edge.
- Instruction ROM:
  - Instance name im; array instr_rom[0:IMEM_WORDS-1] of 32-bit words, loadable by $readmemh.
  - Combinational read at PC[9:2].
  - PC beyond the ROM depth wraps modulo the depth.
- Register file:
  - Instance name register_file; array registers[0:31] of 32-bit words.
  - Two combinational read ports, one synchronous write port.
  - x0 reads 0 and ignores writes.
  - A read of a register being written in the same cycle returns the old value.
- Instruction set, RV32I base:
  - LUI, AUIPC, JAL, JALR (target with bit0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Loads LB/LH/LW/LBU/LHU; stores SB/SH/SW.
  - All OP-IMM and OP ALU operations; shifts use the low 5 bits of the shift amount.
  - FENCE, ECALL, EBREAK and any unknown opcode execute as NOP (PC+4, no writes).
- Data RAM:
  - Little-endian.
  - Combinational read; synchronous write with per-byte enables.
  - Address index = (addr-DMEM_BASE)[11:2].
  - SB writes byte addr[1:0]; SH writes halfword addr[1]; SW writes the whole word.
  - Load extraction uses the same lanes. LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned accesses are not trapped: the low address bits are ignored (word/halfword aligned down).
- Memory map (decoded on addr[31:28]):
  - 4'h8 selects data RAM.
  - 4'hF selects I/O:
    - Loads from IO_BASE+0 return {16'b0, sw}.
    - Loads from IO_BASE+4 return {16'b0, led}.
    - A store of any width to IO_BASE+4 sets led = store data[15:0].
  - Other addresses: loads return 0, stores are ignored.
- Arithmetic: 32-bit wrap-around; SLT/BLT signed, SLTU/BLTU unsigned; SRA arithmetic.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants;
  - funct3 codes for branch, load and store;
  - ALU operation enum;
  - DMEM_BASE and IO_BASE constants.
- One natural sub-module: rv32i_regfile, instantiated as register_file.
- The ALU, decoder, load/store lane logic, instruction ROM (im) and data RAM stay inline in the core.

Test Plan:
1. Word store/load: addi x8,x0,123; lui x9,0x80000; sw x8,0(x9); lw x1,0(x9) -> after 20 cycles x1=123.
2. Halfword: addi x7,x0,532; sh x7,0(x9); lh x3,0(x9) -> x3=532. Then addi x11,x0,-1; sb x11,0(x9), followed by these loads:
   - lb x4,0(x9) -> x4=0xFFFFFFFF.
   - lh x28,0(x9) -> x28=0x000002FF.
   - lbu x29,0(x9) -> x29=0xFF.
   - sw x11,0(x9) then lhu x30,0(x9) -> x30=0x0000FFFF.
3. ALU/branch:
   - addi x1,x0,-5; slti x2,x1,0 -> x2=1; sltiu x3,x1,0 -> x3=0; srai x4,x1,1 -> x4=0xFFFFFFFD.
   - bne x2,x0,+8 skips the next instruction.
   - jal x5,+8 -> x5=PC+4.
4. I/O: sw=16'hA5A5; lui x9,0xF0000; lw x1,0(x9) -> x1=0x0000A5A5. addi x2,x0,0x3C; sw x2,4(x9) -> led=16'h003C on the next cycle.
5. x0 and reset:
   - addi x0,x0,7 -> x0 reads 0.
   - Assert rst for one edge mid-program -> PC=0, x1..x31=0, led=0; data RAM word at 0x80000000 unchanged.
